ram_dump_tx: RTL and testbench
==============================

Name: ram_dump_tx

Overview:
Reads a contiguous byte range from the program RAM and streams it out the UART as 8N1 serial data, LSB first. It is the read-back counterpart of the UART boot loader, which writes RAM from UART_RXD; this block dumps RAM contents back over UART_TXD for host-side verification. It sits beside the soc on the RAM read port and drives the TX line while busy.

Parameters:
CLKS_PER_BIT, 434, clk cycles per UART bit (50 MHz / 115200); must be >= 2
ADDR_BITS, 16, RAM byte-address width

Ports:
clk  input  1  system clock (CLOCK_50 domain)
rst  input  1  asynchronous, active-high reset
start  input  1  single-cycle request to begin a dump; sampled only when busy=0
start_addr  input  ADDR_BITS  first RAM address to dump; latched with start
length  input  ADDR_BITS  number of bytes to dump; latched with start; 0 means no transfer
ram_addr  output  ADDR_BITS  RAM read address
ram_do  input  8  RAM read data; valid one clk after ram_addr is presented
busy  output  1  high from the cycle after an accepted non-zero start until the last stop bit completes
done  output  1  single-cycle pulse at the end of a dump
uart_txd  output  1  serial output; idle high

Behaviour:
- Reset is asynchronous, active-high. While rst=1: uart_txd=1, busy=0, done=0, ram_addr=0, FSM=IDLE, all counters=0. Reset mid-byte aborts immediately; the line returns high with no partial-frame completion.
- FSM states and transitions:
  - IDLE: on start with length!=0, latch addr/count and go to FETCH; busy=1 from the next cycle. On start with length==0, pulse done the next cycle, busy stays 0, remain in IDLE.
  - FETCH: ram_addr=current address for 1 cycle, then go to LATCH.
  - LATCH: capture ram_do into the shift register, then go to START.
  - START: txd=0 for CLKS_PER_BIT cycles, then go to DATA.
  - DATA: 8 bits, LSB first, each held CLKS_PER_BIT cycles; go to STOP after bit 7.
  - STOP: txd=1 for CLKS_PER_BIT cycles. When STOP ends: decrement the remaining count and increment the address. If the remaining count was 1, go to IDLE, pulse done for 1 cycle, and drop busy in that same cycle. Otherwise go to FETCH.
- Per-byte cost: 2 + 10*CLKS_PER_BIT cycles. First start-bit falling edge occurs 3 cycles after the start strobe cycle.
- Address increments modulo 2^ADDR_BITS, so 0xFFFF wraps to 0x0000. length is an unsigned byte count, 1..2^ADDR_BITS-1.
- start while busy=1 is ignored entirely; the latched values are unchanged.
- uart_txd is registered and glitch-free. It is high in IDLE, FETCH and LATCH.
- ram_addr holds its last value outside FETCH. The RAM read has no side effects.

Decomposition:
- Shared package (uart_pkg): UART_START_BIT=0, UART_STOP_BIT=1, UART_DATA_BITS=8, default CLKS_PER_BIT=434, FSM state encoding typedef.
- One sub-module, uart_tx_byte: inputs clk, rst, load, data[7:0]; outputs txd, tx_busy, tx_done. It owns the baud counter, bit counter and shift register.
- ram_dump_tx keeps the address/length counters and the FETCH/LATCH sequencing, and hands each byte to uart_tx_byte.

Test Plan:
- CLKS_PER_BIT=4, RAM[0x10]=0xA5, start_addr=0x10, length=1:
  - txd is low at cycle 3, then bits 1,0,1,0,0,1,0,1, each 4 cycles wide, then high.
  - done pulses exactly once at cycle 43.
  - busy is high during cycles 1..42.
- length=3 at 0x20 with RAM={0x01,0x80,0xFF} -> three back-to-back frames decode to 0x01, 0x80, 0xFF; ram_addr shows 0x20, 0x21, 0x22; a single done pulse at the end.
- start_addr=0xFFFE, length=3 -> reads 0xFFFE, 0xFFFF, 0x0000 in that order.
- length=0 start -> done one cycle later; busy never asserts; txd stays 1.
- Second start (different addr) asserted mid-frame -> ignored; only the original range is transmitted.
- rst asserted during DATA bit 4 -> txd=1, busy=0, done=0 immediately; a following start dumps correctly from scratch.

Source files
------------

// File: rtl/uart_pkg.sv
// UART framing constants and FSM state encodings shared by the RAM dump path.
package uart_pkg;

  localparam logic        UART_START_BIT    = 1'b0;
  localparam logic        UART_STOP_BIT     = 1'b1;
  localparam int unsigned UART_DATA_BITS    = 8;
  localparam int unsigned UART_CLKS_PER_BIT = 434;

  typedef enum logic [1:0] {
    DUMP_IDLE,
    DUMP_FETCH,
    DUMP_LATCH,
    DUMP_SEND
  } dump_state_t;

  typedef enum logic [1:0] {
    TX_IDLE,
    TX_START,
    TX_DATA,
    TX_STOP
  } tx_phase_t;

endpackage

// File: rtl/uart_tx_byte.sv
// 8N1 UART transmitter for a single byte, LSB first, with a registered line output.
module uart_tx_byte
  import uart_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = UART_CLKS_PER_BIT
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       load,
  input  logic [7:0] data,
  output logic       txd,
  output logic       tx_busy,
  output logic       tx_done
);

  localparam int unsigned      CNT_W     = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] BAUD_LAST = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [2:0]       BIT_LAST  = 3'(UART_DATA_BITS - 1);

  tx_phase_t        phase_q, phase_d;
  logic [CNT_W-1:0] baud_q;
  logic [2:0]       bit_q;
  logic [7:0]       shift_q;
  logic             txd_q, txd_d;
  logic             baud_end;

  assign baud_end = (baud_q == BAUD_LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      phase_q <= TX_IDLE;
      txd_q   <= UART_STOP_BIT;
    end else begin
      phase_q <= phase_d;
      txd_q   <= txd_d;
    end
  end

  // tx_done flags the final cycle of the stop bit so the caller can act on the same edge.
  always_comb begin
    phase_d = phase_q;
    txd_d   = txd_q;
    tx_done = 1'b0;
    case (phase_q)
      TX_IDLE: begin
        if (load) begin
          phase_d = TX_START;
          txd_d   = UART_START_BIT;
        end
      end
      TX_START: begin
        if (baud_end) begin
          phase_d = TX_DATA;
          txd_d   = shift_q[0];
        end
      end
      TX_DATA: begin
        if (baud_end) begin
          if (bit_q == BIT_LAST) begin
            phase_d = TX_STOP;
            txd_d   = UART_STOP_BIT;
          end else begin
            txd_d = shift_q[1];
          end
        end
      end
      TX_STOP: begin
        if (baud_end) begin
          phase_d = TX_IDLE;
          tx_done = 1'b1;
        end
      end
      default: phase_d = TX_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      baud_q  <= '0;
      bit_q   <= '0;
      shift_q <= '0;
    end else if (phase_q == TX_IDLE) begin
      baud_q <= '0;
      bit_q  <= '0;
      if (load) shift_q <= data;
    end else begin
      baud_q <= baud_end ? '0 : baud_q + CNT_W'(1);
      if ((phase_q == TX_DATA) && baud_end) begin
        shift_q <= {1'b0, shift_q[7:1]};
        bit_q   <= bit_q + 3'd1;
      end
    end
  end

  assign txd     = txd_q;
  assign tx_busy = (phase_q != TX_IDLE);

endmodule

// File: rtl/ram_dump_tx.sv
// Streams a contiguous RAM byte range out of the UART TX line for host-side read-back.
module ram_dump_tx
  import uart_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = UART_CLKS_PER_BIT,
  parameter int unsigned ADDR_BITS    = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [ADDR_BITS-1:0] start_addr,
  input  logic [ADDR_BITS-1:0] length,
  output logic [ADDR_BITS-1:0] ram_addr,
  input  logic [7:0]           ram_do,
  output logic                 busy,
  output logic                 done,
  output logic                 uart_txd
);

  localparam logic [ADDR_BITS-1:0] ADDR_ONE = ADDR_BITS'(1);

  dump_state_t          state_q, state_d;
  logic [ADDR_BITS-1:0] addr_q;
  logic [ADDR_BITS-1:0] remain_q;
  logic [ADDR_BITS-1:0] ram_addr_q;
  logic                 done_q;

  logic accept, zero_req, byte_end, last_byte, load;
  logic tx_busy, tx_done;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= DUMP_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d   = state_q;
    accept    = 1'b0;
    zero_req  = 1'b0;
    byte_end  = 1'b0;
    last_byte = 1'b0;
    load      = 1'b0;
    case (state_q)
      DUMP_IDLE: begin
        if (start) begin
          if (length != '0) begin
            accept  = 1'b1;
            state_d = DUMP_FETCH;
          end else begin
            zero_req = 1'b1;
          end
        end
      end
      DUMP_FETCH: state_d = DUMP_LATCH;
      DUMP_LATCH: begin
        if (!tx_busy) begin
          load    = 1'b1;
          state_d = DUMP_SEND;
        end
      end
      DUMP_SEND: begin
        if (tx_done) begin
          byte_end  = 1'b1;
          last_byte = (remain_q == ADDR_ONE);
          state_d   = last_byte ? DUMP_IDLE : DUMP_FETCH;
        end
      end
      default: state_d = DUMP_IDLE;
    endcase
  end

  // ram_addr only moves when entering FETCH, so it keeps the last byte's address once idle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      addr_q     <= '0;
      remain_q   <= '0;
      ram_addr_q <= '0;
      done_q     <= 1'b0;
    end else begin
      done_q <= zero_req || last_byte;
      if (accept) begin
        addr_q     <= start_addr;
        remain_q   <= length;
        ram_addr_q <= start_addr;
      end else if (byte_end) begin
        addr_q   <= addr_q + ADDR_ONE;
        remain_q <= remain_q - ADDR_ONE;
        if (!last_byte) ram_addr_q <= addr_q + ADDR_ONE;
      end
    end
  end

  uart_tx_byte #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_tx (
    .clk    (clk),
    .rst    (rst),
    .load   (load),
    .data   (ram_do),
    .txd    (uart_txd),
    .tx_busy(tx_busy),
    .tx_done(tx_done)
  );

  assign ram_addr = ram_addr_q;
  assign busy     = (state_q != DUMP_IDLE);
  assign done     = done_q;

endmodule

// File: tb/tb_ram_dump_tx.sv
// Bench for ram_dump_tx: behavioural RAM, UART frame decoder with expected-frame queue.
module tb_ram_dump_tx;

  localparam int unsigned CPB      = 4;
  localparam int unsigned AW       = 16;
  localparam int          CPB_I    = CPB;
  localparam int          BYTE_CYC = 2 + 10 * CPB_I;

  typedef struct packed {
    logic [15:0] addr;
    logic [7:0]  data;
  } frame_t;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic [AW-1:0] start_addr = '0;
  logic [AW-1:0] length = '0;
  logic [AW-1:0] ram_addr;
  logic [7:0]    ram_do;
  logic          busy, done, uart_txd;

  logic [7:0] mem [0:65535];
  frame_t     exp_q[$];
  int         n_cmp = 0;
  int         n_err = 0;

  ram_dump_tx #(
    .CLKS_PER_BIT(CPB),
    .ADDR_BITS   (AW)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .start_addr(start_addr),
    .length    (length),
    .ram_addr  (ram_addr),
    .ram_do    (ram_do),
    .busy      (busy),
    .done      (done),
    .uart_txd  (uart_txd)
  );

  always #5 clk = ~clk;

  always @(posedge clk) ram_do <= mem[ram_addr];

  // Frame decoder: samples mid-bit on the falling edge, compares each frame with the queue head.
  int          mon_t = -1;
  logic [15:0] mon_addr;
  logic [7:0]  mon_data;
  logic        mon_start, mon_stop;
  frame_t      mon_exp;

  always @(negedge clk) begin
    if (rst) begin
      mon_t = -1;
    end else if (mon_t < 0) begin
      if (uart_txd === 1'b0) begin
        mon_t    = 0;
        mon_addr = ram_addr;
      end
    end else begin
      mon_t++;
      if ((mon_t % CPB_I) == (CPB_I / 2)) begin
        if (mon_t / CPB_I == 0) begin
          mon_start = uart_txd;
        end else if (mon_t / CPB_I <= 8) begin
          mon_data[mon_t / CPB_I - 1] = uart_txd;
        end else begin
          mon_stop = uart_txd;
          mon_t    = -1;
          n_cmp++;
          if (exp_q.size() == 0) begin
            n_err++;
            $display("FAIL frame: got unexpected frame addr=%h data=%h, required no frame",
                     mon_addr, mon_data);
          end else begin
            mon_exp = exp_q.pop_front();
            if ({mon_addr, mon_data, mon_start, mon_stop} !== {mon_exp.addr, mon_exp.data, 2'b01}) begin
              n_err++;
              $display("FAIL frame: got addr=%h data=%h start=%b stop=%b, required addr=%h data=%h start=0 stop=1",
                       mon_addr, mon_data, mon_start, mon_stop, mon_exp.addr, mon_exp.data);
            end
          end
        end
      end
    end
  end

  // Stimulus only: strobe start for cycle 0 and queue the frames the range should produce.
  task automatic kick(input logic [15:0] a, input logic [15:0] n);
    frame_t      f;
    logic [15:0] ad;
    @(posedge clk);
    #1;
    start      = 1'b1;
    start_addr = a;
    length     = n;
    for (int i = 0; i < int'(n); i++) begin
      ad     = a + 16'(i);
      f.addr = ad;
      f.data = mem[ad];
      exp_q.push_back(f);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    @(negedge clk);
    n_cmp++;
    if ({uart_txd, busy, done} !== 3'b100) begin
      n_err++;
      $display("FAIL reset_outputs: got txd/busy/done=%b, required 100", {uart_txd, busy, done});
    end
    n_cmp++;
    if (ram_addr !== 16'h0000) begin
      n_err++;
      $display("FAIL reset_ram_addr: got %h, required 0000", ram_addr);
    end
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic test_single();
    logic [7:0] b;
    logic       e_txd;
    b = 8'hA5;
    mem[16'h0010] = b;
    kick(16'h0010, 16'd1);
    for (int c = 0; c < 50; c++) begin
      @(negedge clk);
      if (c >= 3 && c < 3 + CPB_I)             e_txd = 1'b0;
      else if (c >= 3 + CPB_I && c < 3 + 9 * CPB_I) e_txd = b[(c - 3 - CPB_I) / CPB_I];
      else                                     e_txd = 1'b1;
      n_cmp++;
      if (uart_txd !== e_txd) begin
        n_err++;
        $display("FAIL single_txd c=%0d: got %b, required %b", c, uart_txd, e_txd);
      end
      n_cmp++;
      if (busy !== (c >= 1 && c <= 42)) begin
        n_err++;
        $display("FAIL single_busy c=%0d: got %b, required %b", c, busy, (c >= 1 && c <= 42));
      end
      n_cmp++;
      if (done !== (c == 43)) begin
        n_err++;
        $display("FAIL single_done c=%0d: got %b, required %b", c, done, (c == 43));
      end
      @(posedge clk);
      #1;
      start = 1'b0;
    end
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_err++;
      $display("FAIL single_frames: got %0d frames outstanding, required 0", exp_q.size());
    end
  endtask

  // Shared shape for multi-byte runs: done once at 42N+1, busy high for exactly 42N cycles.
  task automatic test_burst();
    int done_cnt, done_at, busy_cnt;
    mem[16'h0020] = 8'h01;
    mem[16'h0021] = 8'h80;
    mem[16'h0022] = 8'hFF;
    done_cnt = 0; done_at = -1; busy_cnt = 0;
    kick(16'h0020, 16'd3);
    for (int c = 0; c < 3 * BYTE_CYC + 20; c++) begin
      @(negedge clk);
      if (done === 1'b1) begin done_cnt++; done_at = c; end
      if (busy === 1'b1) busy_cnt++;
      @(posedge clk);
      #1;
      start = 1'b0;
    end
    n_cmp++;
    if (done_cnt != 1 || done_at != 3 * BYTE_CYC + 1) begin
      n_err++;
      $display("FAIL burst_done: got %0d pulses at cycle %0d, required 1 at %0d",
               done_cnt, done_at, 3 * BYTE_CYC + 1);
    end
    n_cmp++;
    if (busy_cnt != 3 * BYTE_CYC) begin
      n_err++;
      $display("FAIL burst_busy: got %0d busy cycles, required %0d", busy_cnt, 3 * BYTE_CYC);
    end
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_err++;
      $display("FAIL burst_frames: got %0d frames outstanding, required 0", exp_q.size());
    end
  endtask

  task automatic test_wrap();
    int done_cnt, done_at;
    mem[16'hFFFE] = 8'h5A;
    mem[16'hFFFF] = 8'hC3;
    mem[16'h0000] = 8'h96;
    done_cnt = 0; done_at = -1;
    kick(16'hFFFE, 16'd3);
    for (int c = 0; c < 3 * BYTE_CYC + 20; c++) begin
      @(negedge clk);
      if (done === 1'b1) begin done_cnt++; done_at = c; end
      @(posedge clk);
      #1;
      start = 1'b0;
    end
    n_cmp++;
    if (done_cnt != 1 || done_at != 3 * BYTE_CYC + 1) begin
      n_err++;
      $display("FAIL wrap_done: got %0d pulses at cycle %0d, required 1 at %0d",
               done_cnt, done_at, 3 * BYTE_CYC + 1);
    end
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_err++;
      $display("FAIL wrap_frames: got %0d frames outstanding, required 0", exp_q.size());
    end
  endtask

  task automatic test_zero_len();
    kick(16'h0030, 16'd0);
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      n_cmp++;
      if ({uart_txd, busy, done} !== {1'b1, 1'b0, (c == 1)}) begin
        n_err++;
        $display("FAIL zero_len c=%0d: got txd/busy/done=%b, required %b",
                 c, {uart_txd, busy, done}, {1'b1, 1'b0, (c == 1)});
      end
      @(posedge clk);
      #1;
      start = 1'b0;
    end
  endtask

  task automatic test_ignore_start();
    int done_cnt, done_at;
    done_cnt = 0; done_at = -1;
    kick(16'h0040, 16'd2);
    for (int c = 0; c < 2 * BYTE_CYC + 6 * BYTE_CYC; c++) begin
      @(negedge clk);
      if (done === 1'b1) begin done_cnt++; done_at = c; end
      @(posedge clk);
      #1;
      start = (c == 19);
      if (c == 19) begin
        start_addr = 16'h0080;
        length     = 16'd5;
      end
    end
    n_cmp++;
    if (done_cnt != 1 || done_at != 2 * BYTE_CYC + 1) begin
      n_err++;
      $display("FAIL ignore_done: got %0d pulses at cycle %0d, required 1 at %0d",
               done_cnt, done_at, 2 * BYTE_CYC + 1);
    end
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_err++;
      $display("FAIL ignore_frames: got %0d frames outstanding, required 0", exp_q.size());
    end
  endtask

  task automatic test_reset_mid();
    int done_cnt, done_at;
    mem[16'h0050] = 8'h0F;
    mem[16'h0060] = 8'h3C;
    kick(16'h0050, 16'd2);
    for (int c = 0; c < 24; c++) begin
      @(posedge clk);
      #1;
      start = 1'b0;
    end
    // Cycle 24 sits inside data bit 4, which is a 0 for 0x0F.
    n_cmp++;
    if (uart_txd !== 1'b0) begin
      n_err++;
      $display("FAIL rstmid_pre_txd: got %b, required 0", uart_txd);
    end
    rst = 1'b1;
    #1;
    n_cmp++;
    if ({uart_txd, busy, done} !== 3'b100) begin
      n_err++;
      $display("FAIL rstmid_outputs: got txd/busy/done=%b, required 100", {uart_txd, busy, done});
    end
    exp_q.delete();
    @(negedge clk);
    @(posedge clk);
    #1;
    rst = 1'b0;
    done_cnt = 0; done_at = -1;
    kick(16'h0060, 16'd1);
    for (int c = 0; c < BYTE_CYC + 10; c++) begin
      @(negedge clk);
      if (done === 1'b1) begin done_cnt++; done_at = c; end
      @(posedge clk);
      #1;
      start = 1'b0;
    end
    n_cmp++;
    if (done_cnt != 1 || done_at != BYTE_CYC + 1) begin
      n_err++;
      $display("FAIL rstmid_done: got %0d pulses at cycle %0d, required 1 at %0d",
               done_cnt, done_at, BYTE_CYC + 1);
    end
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_err++;
      $display("FAIL rstmid_frames: got %0d frames outstanding, required 0", exp_q.size());
    end
  endtask

  initial begin
    for (int i = 0; i < 65536; i++) mem[i] = 8'((i * 37) ^ (i >> 8));
    test_reset();
    test_single();
    test_burst();
    test_wrap();
    test_zero_len();
    test_ignore_start();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
